// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: multiplexed N-digit seven-segment scan controller.
// A prescaler paces the digit slots. A dead-time counter blanks every anode
// just after each digit switch to avoid ghosting. Double-buffered
// digit/dp/blank registers only change at frame boundaries.
// Optional feature macro: SSEG_LZ_SUPPRESS_EN enables leading-zero suppression.
module sseg_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 100000,
  parameter int DEADTIME = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   digits,
  input  logic [N_DIGITS-1:0]     dp,
  input  logic [N_DIGITS-1:0]     blank,
  output logic [N_DIGITS-1:0]     sseg_an,
  output logic [6:0]              sseg_ca,
  output logic                    sseg_dp,
  output logic                    frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] DEAD_LOAD = CW'(DEADTIME);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  // Hex to active-low segment code, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'b1000000;
      4'h1:    code = 7'b1111001;
      4'h2:    code = 7'b0100100;
      4'h3:    code = 7'b0110000;
      4'h4:    code = 7'b0011001;
      4'h5:    code = 7'b0010010;
      4'h6:    code = 7'b0000010;
      4'h7:    code = 7'b1111000;
      4'h8:    code = 7'b0000000;
      4'h9:    code = 7'b0010000;
      4'hA:    code = 7'b0001000;
      4'hB:    code = 7'b0000011;
      4'hC:    code = 7'b1000110;
      4'hD:    code = 7'b0100001;
      4'hE:    code = 7'b0000110;
      4'hF:    code = 7'b0001110;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

  // Scan state
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          dead_q, dead_d;
  // Shadow (written by load) and active (displayed) buffers
  logic [4*N_DIGITS-1:0]  shd_dig_q, shd_dig_d, act_dig_q, act_dig_d;
  logic [N_DIGITS-1:0]    shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0]    shd_blank_q, shd_blank_d, act_blank_q, act_blank_d;
  // Registered outputs
  logic [N_DIGITS-1:0]    an_q, an_d;
  logic [6:0]             ca_q, ca_d;
  logic                   dp_q, dp_d;
  logic                   fd_q, fd_d;

  logic                   tick_s;
  logic                   wrap_s;
  logic [N_DIGITS-1:0]    blank_eff_s;
  logic [3:0]             sel_nib_s;
  logic                   sel_dp_s;
  logic                   sel_blank_s;

`ifdef SSEG_LZ_SUPPRESS_EN
  logic [N_DIGITS-1:0]    lz_s;
  logic                   zero_run_s;

  // Leading-zero mask: a digit is suppressed while it and every higher nibble are zero and its dp is off.
  always_comb begin
    lz_s       = '0;
    zero_run_s = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run_s = zero_run_s && (act_dig_q[4*i +: 4] == 4'h0);
      lz_s[i]    = zero_run_s && !act_dp_q[i];
    end
  end

  // Effective blanking merges explicit blank with leading-zero suppression.
  always_comb begin
    blank_eff_s = act_blank_q | lz_s;
  end
`else
  // Effective blanking is the explicit per-digit blank only.
  always_comb begin
    blank_eff_s = act_blank_q;
  end
`endif

  // Prescaler, scan index, dead counter and buffer next-state.
  always_comb begin
    tick_s = (cnt_q == CNT_LAST);
    wrap_s = tick_s && (idx_q == IDX_LAST);

    if (tick_s) begin
      cnt_d  = '0;
      dead_d = DEAD_LOAD;
      if (wrap_s) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
      if (dead_q != '0) begin
        dead_d = dead_q - CW'(1);
      end else begin
        dead_d = dead_q;
      end
    end

    if (load) begin
      shd_dig_d   = digits;
      shd_dp_d    = dp;
      shd_blank_d = blank;
    end else begin
      shd_dig_d   = shd_dig_q;
      shd_dp_d    = shd_dp_q;
      shd_blank_d = shd_blank_q;
    end

    // Active copy takes the shadow as it stood before this edge.
    if (wrap_s) begin
      act_dig_d   = shd_dig_q;
      act_dp_d    = shd_dp_q;
      act_blank_d = shd_blank_q;
    end else begin
      act_dig_d   = act_dig_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
    end
  end

  // Select the current digit's data and form the next output values.
  always_comb begin
    sel_nib_s   = 4'h0;
    sel_dp_s    = 1'b0;
    sel_blank_s = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_nib_s   = act_dig_q[4*i +: 4];
        sel_dp_s    = act_dp_q[i];
        sel_blank_s = blank_eff_s[i];
      end else begin
        sel_nib_s   = sel_nib_s;
      end
    end

    for (int i = 0; i < N_DIGITS; i++) begin
      an_d[i] = !((idx_q == IW'(i)) && (dead_q == '0) && !sel_blank_s);
    end

    if (sel_blank_s) begin
      ca_d = 7'b1111111;
      dp_d = 1'b1;
    end else begin
      ca_d = seg_decode(sel_nib_s);
      dp_d = !sel_dp_s;
    end

    fd_d = wrap_s;
  end

  // State and output registers with synchronous reset; reset masks load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      dead_q      <= '0;
      shd_dig_q   <= '0;
      shd_dp_q    <= '0;
      shd_blank_q <= '1;
      act_dig_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '1;
      an_q        <= '1;
      ca_q        <= 7'b1111111;
      dp_q        <= 1'b1;
      fd_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dead_q      <= dead_d;
      shd_dig_q   <= shd_dig_d;
      shd_dp_q    <= shd_dp_d;
      shd_blank_q <= shd_blank_d;
      act_dig_q   <= act_dig_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      an_q        <= an_d;
      ca_q        <= ca_d;
      dp_q        <= dp_d;
      fd_q        <= fd_d;
    end
  end

  assign sseg_an    = an_q;
  assign sseg_ca    = ca_q;
  assign sseg_dp    = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with N_DIGITS=4, PRESCALE=4, DEADTIME=1.
// Each frame is 16 cycles: 4 slots of 4 cycles, the first of each slot dark.
module tb_sseg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  sseg_an;
  logic [6:0]  sseg_ca;
  logic        sseg_dp;
  logic        frame_done;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef SSEG_LZ_SUPPRESS_EN
  localparam logic [3:0] LZ_BLK = 4'b1100;
`else
  localparam logic [3:0] LZ_BLK = 4'b0000;
`endif

  sseg_scan_ctrl #(
    .N_DIGITS (4),
    .PRESCALE (4),
    .DEADTIME (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .digits     (digits),
    .dp         (dp),
    .blank      (blank),
    .sseg_an    (sseg_an),
    .sseg_ca    (sseg_ca),
    .sseg_dp    (sseg_dp),
    .frame_done (frame_done)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report a mismatch.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-written expected cathode codes (gfedcba, active-low).
  function automatic logic [6:0] exp_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h5: return 7'b0010010;
      4'h8: return 7'b0000000;
      4'hA: return 7'b0001000;
      4'hF: return 7'b0001110;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  // Check one full 16-cycle frame; optionally strobe load after cycle ld_c.
  task automatic check_frame(input string lbl, input logic [15:0] dig, input logic [3:0] blk,
                             input logic [3:0] dpv, input int ld_c, input logic [15:0] ld_dig,
                             input logic [3:0] ld_blk, input logic [3:0] ld_dp);
    int s;
    int ph;
    logic [3:0] e_an;
    logic [6:0] e_ca;
    logic       e_dp;
    for (int c = 1; c <= 16; c++) begin
      step();
      s  = (c - 1) / 4;
      ph = (c - 1) % 4;
      if (ph == 0 || blk[s]) e_an = 4'hF;
      else                   e_an = ~(4'b0001 << s);
      e_ca = blk[s] ? 7'b1111111 : exp_seg(dig[4*s +: 4]);
      e_dp = blk[s] ? 1'b1 : ~dpv[s];
      chk($sformatf("%s c%0d an", lbl, c), 32'(sseg_an), 32'(e_an));
      chk($sformatf("%s c%0d ca", lbl, c), 32'(sseg_ca), 32'(e_ca));
      chk($sformatf("%s c%0d dp", lbl, c), 32'(sseg_dp), 32'(e_dp));
      chk($sformatf("%s c%0d frame_done", lbl, c), 32'(frame_done), 32'(c == 16));
      if (c == ld_c) begin
        load   = 1'b1;
        digits = ld_dig;
        blank  = ld_blk;
        dp     = ld_dp;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset for 3 cycles with a load strobe that must be ignored.
    rst    = 1'b1;
    load   = 1'b1;
    digits = 16'hFFFF;
    blank  = 4'b0000;
    dp     = 4'b1111;
    for (int i = 0; i < 3; i++) step();
    chk("rst an", 32'(sseg_an), 32'h0000000F);
    chk("rst ca", 32'(sseg_ca), 32'h0000007F);
    chk("rst dp", 32'(sseg_dp), 32'h00000001);
    chk("rst frame_done", 32'(frame_done), 32'h00000000);
    rst  = 1'b0;
    load = 1'b0;

    // Frame A: reset blanks active; first frame_done at cycle 16.
    check_frame("A", 16'h0000, 4'hF, 4'h0, 0, 16'h0000, 4'h0, 4'h0);
    // Frame B: shadow still reset (load in reset ignored); load 3210 mid-frame.
    check_frame("B", 16'h0000, 4'hF, 4'h0, 2, 16'h3210, 4'b0000, 4'b0000);
    // Frame C: 3210 shown; load in the wrap-tick cycle.
    check_frame("C", 16'h3210, 4'b0000, 4'b0000, 15, 16'hFA18, 4'b0100, 4'b0001);
    // Frame D: old value still shown for this whole frame.
    check_frame("D", 16'h3210, 4'b0000, 4'b0000, 0, 16'h0000, 4'h0, 4'h0);
    // Frame E: FA18 with digit 2 blanked and dp on digit 0; load 0050.
    check_frame("E", 16'hFA18, 4'b0100, 4'b0001, 3, 16'h0050, 4'b0000, 4'b0000);
    // Frame F: 0050, leading zeros dark only with suppression built in.
    check_frame("F", 16'h0050, LZ_BLK, 4'b0000, 2, 16'h1234, 4'b0000, 4'b0000);

    // Reset mid-slot during digit 2; pending shadow and load discarded.
    for (int i = 0; i < 10; i++) step();
    rst    = 1'b1;
    load   = 1'b1;
    digits = 16'h8888;
    blank  = 4'b0000;
    step();
    chk("mid rst an", 32'(sseg_an), 32'h0000000F);
    chk("mid rst ca", 32'(sseg_ca), 32'h0000007F);
    chk("mid rst dp", 32'(sseg_dp), 32'h00000001);
    chk("mid rst frame_done", 32'(frame_done), 32'h00000000);
    rst  = 1'b0;
    load = 1'b0;
    check_frame("G", 16'h0000, 4'hF, 4'h0, 0, 16'h0000, 4'h0, 4'h0);
    check_frame("H", 16'h0000, 4'hF, 4'h0, 0, 16'h0000, 4'h0, 4'h0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter PRESCALE, default 100000: clock cycles per digit slot, legal minimum 4.
REQ-003 Parameter DEADTIME, default 2: cycles all anodes are forced off after each digit switch, legal range 0..PRESCALE-2.
REQ-004 Ports: clk, in, 1 bit, sole clock; rst, in, 1 bit, synchronous active-high reset.
REQ-005 Port load, in, 1 bit: single-cycle strobe that captures digits, dp and blank into the shadow registers.
REQ-006 Port digits, in, 4*N_DIGITS bits: hex nibble per digit; digit i is bits [4i+3:4i]; digit 0 is rightmost.
REQ-007 Port dp, in, N_DIGITS bits: decimal point request per digit, 1 = lit.
REQ-008 Port blank, in, N_DIGITS bits: per-digit blanking, 1 = digit dark.
REQ-009 Port sseg_an, out, N_DIGITS bits: anodes, active-low.
REQ-010 Port sseg_ca, out, 7 bits: cathodes, active-low, bit 0 = segment a ... bit 6 = segment g.
REQ-011 Port sseg_dp, out, 1 bit: decimal point cathode, active-low.
REQ-012 Port frame_done, out, 1 bit: one-cycle pulse when the scan wraps from digit N_DIGITS-1 to digit 0.

Function
REQ-013 Prescaler SHALL count 0..PRESCALE-1 and wrap to 0; a tick SHALL occur on each cycle where the count equals PRESCALE-1.
REQ-014 On each tick, scan index idx SHALL advance by 1, wrapping from N_DIGITS-1 to 0.
REQ-015 frame_done SHALL be 1 exactly on the cycle after a tick that wraps idx to 0, and 0 otherwise.
REQ-016 On each tick, a dead counter SHALL load DEADTIME and then decrement to 0; all sseg_an bits SHALL be 1 while the dead counter is nonzero.
REQ-017 When load=1, shadow registers SHALL capture digits, dp and blank at that edge; a later load SHALL overwrite the shadow.
REQ-018 On each tick that wraps idx to 0, active registers SHALL copy the shadow value held before that edge; a load in that same cycle SHALL appear only at the next frame.
REQ-019 sseg_an[i] SHALL be 0 only when i==idx, the dead counter is 0, and active blank[i]==0; all other anode bits SHALL be 1.
REQ-020 sseg_ca SHALL decode the active nibble of digit idx with the standard hex table, segments a..g, active-low.
REQ-021 Required cathode codes: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
REQ-022 sseg_dp SHALL equal the inverse of active dp[idx].
REQ-023 sseg_ca and sseg_dp SHALL be 1111111 and 1 whenever the selected digit is blanked.
REQ-024 sseg_an, sseg_ca, sseg_dp and frame_done SHALL be registered, lagging idx and dead-counter state by exactly one cycle.

Reset
REQ-025 While rst=1 at an edge: prescaler, idx and dead counter SHALL clear to 0.
REQ-026 On the same reset edge: shadow and active digits and dp SHALL clear to 0, and shadow and active blank SHALL set to all ones.
REQ-027 Outputs on the cycle after reset SHALL be: sseg_an all ones, sseg_ca 1111111, sseg_dp 1, frame_done 0.
REQ-028 Reset mid-scan SHALL abandon the current slot and discard any pending shadow contents.
REQ-029 load SHALL be ignored while rst=1.

Configuration
REQ-030 Macro SSEG_LZ_SUPPRESS_EN, when defined, SHALL enable leading-zero suppression.
REQ-031 With suppression on: a digit i>0 SHALL be treated as blanked when its active nibble and all higher nibbles are 0 and its dp is 0; digit 0 SHALL never be suppressed.
REQ-032 With SSEG_LZ_SUPPRESS_EN undefined, no suppression logic SHALL exist, and zeros SHALL display as 0 unless blank is set.

Verification (N_DIGITS=4, PRESCALE=4, DEADTIME=1)
REQ-033 Reset held 3 cycles, then released -> sseg_an=1111 until the first frame transfer; frame_done first pulses 16 cycles after release.
REQ-034 load with digits=0x3210, blank=0000, dp=0000 before the first wrap -> after transfer, anodes go 1110,1101,1011,0111 in turn, each low for 3 of 4 cycles, with 1-cycle all-off gaps; cathodes show 1000000 then 1111001 and onward.
REQ-035 load in the same cycle as the wrap tick -> the old value is shown for the full next frame; the new value appears one frame later.
REQ-036 blank=0100, dp=0001 -> digit 2 anode never goes low; sseg_dp=0 only during the digit 0 slot.
REQ-037 With SSEG_LZ_SUPPRESS_EN, digits=0x0050 -> digits 3 and 2 are dark and digits 1 and 0 show 5 and 0; without the macro, 0050 is shown.
REQ-038 rst asserted mid-slot during digit 2 -> on the next cycle all outputs return to reset values and idx restarts at 0.
